// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine: ROM image codes,
// the transparent colour key and the per-sprite explosion FSM states.
package sprite_pkg;

    // Image select codes presented on rom_img
    localparam logic [2:0] IMG_N    = 3'd0;
    localparam logic [2:0] IMG_E    = 3'd1;
    localparam logic [2:0] IMG_S    = 3'd2;
    localparam logic [2:0] IMG_W    = 3'd3;
    localparam logic [2:0] IMG_BOOM = 3'd4;

    // Pixels of this colour are see-through
    localparam logic [11:0] TRANSPARENT = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RESPAWN = 2'd2
    } burst_state_e;

    // Eight heading codes collapse onto four images; odd codes
    // round down to the preceding cardinal direction.
    function automatic logic [2:0] heading_img(input logic [2:0] code);
        return {1'b0, code[2:1]};
    endfunction

endpackage

// File: rtl/sprite_burst_fsm.sv
// Per-sprite explosion sequencer: IDLE -> BURST -> RESPAWN -> IDLE.
// Ports: clk, reset (async active-low), hit_i strobe,
//        burst_o (explosion shown), sprite_reset_o (respawn pulse).
module sprite_burst_fsm
    import sprite_pkg::*;
#(
    parameter logic [31:0] BURST_CYCLES   = 32'h3000000,
    parameter logic [31:0] RESPAWN_CYCLES = 32'd16
) (
    input  logic clk,
    input  logic reset,
    input  logic hit_i,
    output logic burst_o,
    output logic sprite_reset_o
);

    burst_state_e state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        burst_o        = 1'b0;
        sprite_reset_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit_i) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                burst_o = 1'b1;
                // A fresh hit extends the explosion from the start
                if (hit_i) begin
                    cnt_d = '0;
                end else if (cnt_q == BURST_CYCLES - 32'd1) begin
                    state_d = ST_RESPAWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESPAWN: begin
                sprite_reset_o = 1'b1;
                if (cnt_q == RESPAWN_CYCLES - 32'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite renderer: hit-tests each sprite against the scan position,
// addresses the sprite image ROMs, and picks the lowest-index opaque pixel.
// Ports: clk, reset (async active-low), pixel_column/pixel_row scan position,
//        loc_x/loc_y/orient/sprite_en/hit per sprite, rom_addr/rom_img out,
//        rom_data in (one clock later), icon/icon_flag/icon_id winner,
//        burst/sprite_reset per-sprite explosion status.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES    = 4,
    parameter int SPRITE_W       = 16,
    parameter int X_SCALE        = 8,
    parameter int Y_SCALE        = 6,
    parameter int BURST_CYCLES   = 32'h3000000,
    parameter int RESPAWN_CYCLES = 16,
    localparam int AW            = $clog2(SPRITE_W * SPRITE_W),
    localparam int LW            = $clog2(SPRITE_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [11:0]               pixel_column,
    input  logic [11:0]               pixel_row,
    input  logic [8*NUM_SPRITES-1:0]  loc_x,
    input  logic [8*NUM_SPRITES-1:0]  loc_y,
    input  logic [3*NUM_SPRITES-1:0]  orient,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic [NUM_SPRITES-1:0]    hit,
    output logic [AW*NUM_SPRITES-1:0] rom_addr,
    output logic [3*NUM_SPRITES-1:0]  rom_img,
    input  logic [12*NUM_SPRITES-1:0] rom_data,
    output logic [11:0]               icon,
    output logic                      icon_flag,
    output logic [2:0]                icon_id,
    output logic [NUM_SPRITES-1:0]    burst,
    output logic [NUM_SPRITES-1:0]    sprite_reset
);

    // Stage 0: hit test and ROM addressing
    logic [AW*NUM_SPRITES-1:0] rom_addr_q, rom_addr_d;
    logic [3*NUM_SPRITES-1:0]  rom_img_q, rom_img_d;
    logic [NUM_SPRITES-1:0]    in0_q, in0_d;

    // Stage 1: ROM data aligned with its inside flag
    logic [12*NUM_SPRITES-1:0] data1_q;
    logic [NUM_SPRITES-1:0]    in1_q;

    // Stage 2: winner
    logic [11:0] icon_q, icon_d;
    logic        flag_q, flag_d;
    logic [2:0]  id_q, id_d;

    logic [12:0] pc13, pr13;
    assign pc13 = {1'b0, pixel_column};
    assign pr13 = {1'b0, pixel_row};

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [12:0]   col, row;
        logic          in_x, in_y;
        logic [LW-1:0] dx, dy;

        assign col = {1'b0, 12'(32'(loc_x[8*g +: 8]) * X_SCALE)};
        assign row = {1'b0, 12'(32'(loc_y[8*g +: 8]) * Y_SCALE)};

        // 13-bit bounds so a sprite near 4095 cannot wrap to 0
        assign in_x = (pc13 >= col) && (pc13 < col + 13'(SPRITE_W));
        assign in_y = (pr13 >= row) && (pr13 < row + 13'(SPRITE_W));

        // Offsets stay below SPRITE_W, so only the low bits matter
        assign dx = pixel_column[LW-1:0] - col[LW-1:0];
        assign dy = pixel_row[LW-1:0] - row[LW-1:0];

        assign in0_d[g] = sprite_en[g] & in_x & in_y;
        assign rom_addr_d[AW*g +: AW] = in0_d[g] ? {dy, dx} : '0;
        assign rom_img_d[3*g +: 3] =
            burst[g] ? IMG_BOOM : heading_img(orient[3*g +: 3]);

        sprite_burst_fsm #(
            .BURST_CYCLES   (32'(BURST_CYCLES)),
            .RESPAWN_CYCLES (32'(RESPAWN_CYCLES))
        ) u_fsm (
            .clk            (clk),
            .reset          (reset),
            .hit_i          (hit[g]),
            .burst_o        (burst[g]),
            .sprite_reset_o (sprite_reset[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_q <= '0;
            rom_img_q  <= '0;
            in0_q      <= '0;
            data1_q    <= '0;
            in1_q      <= '0;
            icon_q     <= '0;
            flag_q     <= 1'b0;
            id_q       <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            rom_img_q  <= rom_img_d;
            in0_q      <= in0_d;
            data1_q    <= rom_data;
            in1_q      <= in0_q;
            icon_q     <= icon_d;
            flag_q     <= flag_d;
            id_q       <= id_d;
        end
    end

    // Scan from the top index down so the lowest opaque index wins;
    // with no winner the colour and id are held.
    always_comb begin
        icon_d = icon_q;
        id_d   = id_q;
        flag_d = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (in1_q[i] && (data1_q[12*i +: 12] != TRANSPARENT)) begin
                icon_d = data1_q[12*i +: 12];
                id_d   = 3'(i);
                flag_d = 1'b1;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_img   = rom_img_q;
    assign icon      = icon_q;
    assign icon_flag = flag_q;
    assign icon_id   = id_q;

endmodule
